// File: rtl/l0_cache_array.sv
// L0 data cache storage array.
// Holds data, tag and per-byte valid bits for every entry. The write port comes
// from the cache write controller. The read port is combinational and serves the
// EX-stage lookup and the controller's valid-bit merge. A sequential
// invalidate-all sweep clears the valid bits after reset and on a flush request.
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_cache_write_*             write port: enable, byte enables, index, data, tag, valid
//   i_read_index/tag/byte_mask  lookup request
//   i_invalidate_req            start (or restart) an invalidate-all sweep
//   o_read_data/tag/valid       stored contents at i_read_index (valid forced 0 while busy)
//   o_hit                       lookup hit
//   o_busy                      sweep in progress
module l0_cache_array #(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned CacheIndexWidth = 7,
    parameter int unsigned CacheTagWidth   = 7
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_cache_write_enable,
    input  logic [XLEN/8-1:0]          i_cache_byte_write_enable,
    input  logic [CacheIndexWidth-1:0] i_cache_write_index,
    input  logic [XLEN-1:0]            i_cache_write_data,
    input  logic [CacheTagWidth-1:0]   i_cache_write_tag,
    input  logic [XLEN/8-1:0]          i_cache_write_valid,
    input  logic [CacheIndexWidth-1:0] i_read_index,
    input  logic [CacheTagWidth-1:0]   i_read_tag,
    input  logic [XLEN/8-1:0]          i_read_byte_mask,
    input  logic                       i_invalidate_req,
    output logic [XLEN-1:0]            o_read_data,
    output logic [CacheTagWidth-1:0]   o_read_tag,
    output logic [XLEN/8-1:0]          o_read_valid,
    output logic                       o_hit,
    output logic                       o_busy
);

    localparam int unsigned NumBytes = XLEN / 8;
    localparam int unsigned Depth    = 2 ** CacheIndexWidth;
    localparam logic [CacheIndexWidth-1:0] LastIdx = CacheIndexWidth'(Depth - 1);

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_e;

    state_e                     state_q, state_d;
    logic [CacheIndexWidth-1:0] sweep_idx_q, sweep_idx_d;
    logic                       wr_commit;
    logic                       sweep_clear;

    logic [XLEN-1:0]          data_q  [Depth];
    logic [CacheTagWidth-1:0] tag_q   [Depth];
    logic [NumBytes-1:0]      valid_q [Depth];

    // Sweep state register; reset parks the array in a fresh sweep.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= SWEEP;
            sweep_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
        end
    end

    // Next-state logic; an invalidate request always wins over a write.
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        wr_commit   = 1'b0;
        sweep_clear = 1'b0;
        unique case (state_q)
            SWEEP: begin
                sweep_clear = 1'b1;
                if (i_invalidate_req) begin
                    sweep_idx_d = '0;
                end else if (sweep_idx_q == LastIdx) begin
                    state_d     = IDLE;
                    sweep_idx_d = '0;
                end else begin
                    sweep_idx_d = sweep_idx_q + CacheIndexWidth'(1);
                end
            end
            IDLE: begin
                if (i_invalidate_req) begin
                    state_d     = SWEEP;
                    sweep_idx_d = '0;
                end else begin
                    wr_commit = i_cache_write_enable;
                end
            end
            default: begin
                state_d     = SWEEP;
                sweep_idx_d = '0;
            end
        endcase
    end

    // Storage; no reset on any array, valid bits are cleared only by the sweep.
    always_ff @(posedge i_clk) begin
        if (sweep_clear) begin
            valid_q[sweep_idx_q] <= '0;
        end
        if (wr_commit) begin
            tag_q[i_cache_write_index]   <= i_cache_write_tag;
            valid_q[i_cache_write_index] <= i_cache_write_valid;
            for (int unsigned b = 0; b < NumBytes; b++) begin
                if (i_cache_byte_write_enable[b]) begin
                    data_q[i_cache_write_index][8*b +: 8] <= i_cache_write_data[8*b +: 8];
                end
            end
        end
    end

    // Combinational read port; same-cycle writes are not bypassed.
    assign o_busy       = (state_q == SWEEP);
    assign o_read_data  = data_q[i_read_index];
    assign o_read_tag   = tag_q[i_read_index];
    assign o_read_valid = o_busy ? '0 : valid_q[i_read_index];

    // Hit needs every requested byte valid and a tag match.
    assign o_hit = ~o_busy & (|i_read_byte_mask) & (o_read_tag == i_read_tag)
                 & (&(o_read_valid | ~i_read_byte_mask));

endmodule
